// File: rtl/enhanced_stopwatch_transmit_interface.sv
// Snapshots the stopwatch time on a transmit tick and streams it as "MM:SS.T\r\n" into the UART TX FIFO.
// Define STOPWATCH_TX_DIR_CHAR_EN to prepend a '+'/'-' count-direction byte (10-byte line).
module enhanced_stopwatch_transmit_interface #(
  parameter logic [7:0] SEP_MS = 8'h3A,
  parameter logic [7:0] SEP_ST = 8'h2E
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_up,
  input  logic [3:0] i_min1,
  input  logic [3:0] i_min0,
  input  logic [3:0] i_sec1,
  input  logic [3:0] i_sec0,
  input  logic [3:0] i_tenth,
  input  logic       i_tx_full,
  output logic       o_wr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef STOPWATCH_TX_DIR_CHAR_EN
  localparam int LINE_LEN = 10;
  localparam int DIG_BASE = 1;
`else
  localparam int LINE_LEN = 9;
  localparam int DIG_BASE = 0;
`endif
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  logic [1:0]      state_reg, state_next;
  logic [3:0]      index_reg, index_next;
  // Digit order: [4]=min1, [3]=min0, [2]=sec1, [1]=sec0, [0]=tenth
  logic [4:0][3:0] digit_reg;
  logic [4:0][7:0] digit_char;
  logic [3:0]      pos;
  logic [7:0]      char_sel;
  logic            wr;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_enc
      assign digit_char[gi] = (digit_reg[gi] <= 4'd9) ? {4'h3, digit_reg[gi]} : 8'h3F;
    end
  endgenerate

`ifdef STOPWATCH_TX_DIR_CHAR_EN
  logic up_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      up_reg <= 1'b0;
    else if (state_reg == IDLE && i_start)
      up_reg <= i_up;
  end
`else
  logic unused_up;
  assign unused_up = i_up;
`endif

  // Position within the time portion of the line, independent of the direction byte
  assign pos = index_reg - 4'(DIG_BASE);

  always_comb begin
    char_sel = 8'h00;
    case (pos)
      4'd0:    char_sel = digit_char[4];
      4'd1:    char_sel = digit_char[3];
      4'd2:    char_sel = SEP_MS;
      4'd3:    char_sel = digit_char[2];
      4'd4:    char_sel = digit_char[1];
      4'd5:    char_sel = SEP_ST;
      4'd6:    char_sel = digit_char[0];
      4'd7:    char_sel = 8'h0D;
      4'd8:    char_sel = 8'h0A;
      default: char_sel = 8'h00;
    endcase
`ifdef STOPWATCH_TX_DIR_CHAR_EN
    if (index_reg == 4'd0)
      char_sel = up_reg ? 8'h2B : 8'h2D;
`endif
  end

  assign wr = (state_reg == SEND) && !i_tx_full;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = SEND;
          index_next = 4'd0;
        end
      end
      SEND: begin
        if (wr) begin
          if (index_reg == LAST_IDX) begin
            state_next = DONE;
            index_next = 4'd0;
          end else begin
            index_next = index_reg + 4'd1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      index_reg <= 4'd0;
      digit_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      if (state_reg == IDLE && i_start)
        digit_reg <= {i_min1, i_min0, i_sec1, i_sec0, i_tenth};
    end
  end

  assign o_wr      = wr;
  assign o_wr_data = (state_reg == SEND) ? char_sel : 8'h00;
  assign o_busy    = (state_reg == SEND);
  assign o_done    = (state_reg == DONE);

endmodule

// File: tb/tb_enhanced_stopwatch_transmit_interface.sv
// Directed bench for enhanced_stopwatch_transmit_interface; a negedge monitor logs every FIFO write.
module tb_enhanced_stopwatch_transmit_interface;

`ifdef STOPWATCH_TX_DIR_CHAR_EN
  localparam int LEN = 10;
`else
  localparam int LEN = 9;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset, i_start, i_up, i_tx_full;
  logic [3:0] i_min1, i_min0, i_sec1, i_sec0, i_tenth;
  logic       o_wr, o_busy, o_done;
  logic [7:0] o_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int line_no = 0;

  logic [7:0] wr_q[$];
  int         wr_cyc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  enhanced_stopwatch_transmit_interface dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_up      (i_up),
    .i_min1    (i_min1),
    .i_min0    (i_min0),
    .i_sec1    (i_sec1),
    .i_sec0    (i_sec0),
    .i_tenth   (i_tenth),
    .i_tx_full (i_tx_full),
    .o_wr      (o_wr),
    .o_wr_data (o_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_wr) begin
      wr_q.push_back(o_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_time(input logic [3:0] m1, m0, s1, s0, t);
    i_min1 = m1; i_min0 = m0; i_sec1 = s1; i_sec0 = s0; i_tenth = t;
  endtask

  // Returns the cycle number of the edge that samples i_start
  task automatic pulse_start(output int c);
    wr_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    c = cyc;
  endtask

  task automatic finish_line(input string name, input int c, input int exp_cycles,
                             input logic [7:0] exp[$]);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge i_clk);
      n++;
    end
    check({name, "_timeout"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) @(posedge i_clk);
    #1;
    check({name, "_count"}, 32'(wr_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_byte%0d", name, i), (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF, 32'(exp[i]));
    if (wr_cyc_q.size() > 0)
      check({name, "_first_cyc"}, 32'(wr_cyc_q[0] - c), 32'd0);
    check({name, "_done_cyc"}, 32'(done_cyc - c), 32'(exp_cycles));
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_busy_after"}, 32'(o_busy), 32'd0);
    line_no++;
    $display("line %0d (%s): %0d bytes written, done %0d cycles after start", line_no, name,
             wr_q.size(), done_cyc - c);
  endtask

  initial begin
    logic [7:0] e_std[$];
    logic [7:0] e_bad[$];
    logic [7:0] e_zero_dn[$];
    logic [7:0] e_zero_up[$];
    int c;

    e_std     = '{8'h30, 8'h31, 8'h3A, 8'h32, 8'h33, 8'h2E, 8'h34, 8'h0D, 8'h0A};
    e_bad     = '{8'h3F, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A};
    e_zero_dn = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A};
    e_zero_up = e_zero_dn;
`ifdef STOPWATCH_TX_DIR_CHAR_EN
    e_std.push_front(8'h2B);
    e_bad.push_front(8'h2B);
    e_zero_dn.push_front(8'h2D);
    e_zero_up.push_front(8'h2B);
`endif

    i_reset = 1'b1; i_start = 1'b0; i_up = 1'b1; i_tx_full = 1'b0;
    set_time(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_wr", 32'(o_wr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_data", 32'(o_wr_data), 32'h00);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);

    // 1: plain line, FIFO never full
    pulse_start(c);
    finish_line("basic", c, LEN, e_std);

    // 2: FIFO full for 3 cycles while the 4th byte is presented
    pulse_start(c);
    repeat (3) @(posedge i_clk);
    #1 i_tx_full = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("stall_wr", 32'(o_wr), 32'd0);
      check("stall_data", 32'(o_wr_data), 32'(e_std[3]));
      @(posedge i_clk);
    end
    #1 i_tx_full = 1'b0;
    finish_line("stall", c, LEN + 3, e_std);

    // 3: restart request and time change during the line are ignored
    pulse_start(c);
    @(posedge i_clk);
    #1 i_start = 1'b1;
    set_time(4'd5, 4'd9, 4'd5, 4'd9, 4'd9);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    finish_line("snapshot", c, LEN, e_std);
    set_time(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);

    // 4: non-BCD digit encodes as '?'
    set_time(4'hA, 4'd0, 4'd0, 4'd0, 4'd0);
    pulse_start(c);
    finish_line("bad_digit", c, LEN, e_bad);

    // 5: reset after the 5th byte aborts the line immediately
    set_time(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    pulse_start(c);
    repeat (5) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    check("abort_wr", 32'(o_wr), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check("abort_count", 32'(wr_q.size()), 32'd5);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    $display("line aborted by reset: %0d bytes written", wr_q.size());
    pulse_start(c);
    finish_line("after_reset", c, LEN, e_std);

    // 6: direction byte (only present when the feature is built in)
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    i_up = 1'b0;
    pulse_start(c);
    finish_line("zero_down", c, LEN, e_zero_dn);
    i_up = 1'b1;
    pulse_start(c);
    finish_line("zero_up", c, LEN, e_zero_up);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
